// File: rtl/rand_arbiter.sv
// Two-requester arbiter gated by an external LFSR word: grants alternate on ties,
// each grant is followed by a fixed idle gap, and an all-zero LFSR word is flagged sticky.
module rand_arbiter #(
  parameter int unsigned GAP = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [4:0] rnd_in,
  input  logic       run,
  input  logic [1:0] req,
  output logic [1:0] ack,
  output logic [4:0] rnd_out,
  output logic       busy,
  output logic [7:0] grant_cnt,
  output logic       lfsr_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_GAP  = 1'b1
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

  state_t     r_state;
  logic [3:0] r_gap_cnt;
  logic       r_last;

  logic w_grant;
  logic w_winner;

  // Handshake: req is a level held until the matching ack pulse; ack is a
  // single-cycle registered pulse and rnd_out is valid from that cycle on.
  assign w_grant  = (r_state == S_IDLE) && run && (req != 2'b00) && (rnd_in != 5'd0);
  // On a tie the lane that did not win last time takes the grant.
  assign w_winner = (req == 2'b11) ? ~r_last : req[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= 4'd0;
      r_last    <= 1'b1;
      ack       <= 2'b00;
      rnd_out   <= 5'd0;
      busy      <= 1'b0;
      grant_cnt <= 8'd0;
      lfsr_err  <= 1'b0;
    end else begin
      ack <= 2'b00;
      if (rnd_in == 5'd0) begin
        lfsr_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            ack       <= w_winner ? 2'b10 : 2'b01;
            rnd_out   <= rnd_in;
            r_last    <= w_winner;
            r_gap_cnt <= GAP_LOAD;
            grant_cnt <= grant_cnt + 8'd1;
            r_state   <= S_GAP;
            busy      <= 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == 4'd0) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rand_arbiter.sv
// Bench for rand_arbiter: vector table, directed multi-cycle sequences, and
// randomized traffic compared against an edge-counting reference model.
module tb_rand_arbiter;

  localparam int unsigned GAP = 4;

  logic       clk;
  logic       rstn;
  logic [4:0] rnd_in;
  logic       run;
  logic [1:0] req;
  logic [1:0] ack;
  logic [4:0] rnd_out;
  logic       busy;
  logic [7:0] grant_cnt;
  logic       lfsr_err;

  int n_checks = 0;
  int n_errors = 0;

  rand_arbiter #(.GAP(GAP)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rnd_in    (rnd_in),
    .run       (run),
    .req       (req),
    .ack       (ack),
    .rnd_out   (rnd_out),
    .busy      (busy),
    .grant_cnt (grant_cnt),
    .lfsr_err  (lfsr_err)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Grants are spaced by edge count: a new grant may occur GAP+1 edges after the previous one.
  int         m_edge;
  int         m_g;
  bit         m_have;
  bit         m_last;
  logic [1:0] m_ack;
  logic [4:0] m_rnd;
  logic [7:0] m_cnt;
  bit         m_err;
  bit         m_busy;

  function automatic void model_reset();
    m_edge = 0; m_g = 0; m_have = 0; m_last = 1;
    m_ack = 2'b00; m_rnd = 5'd0; m_cnt = 8'd0; m_err = 0; m_busy = 0;
  endfunction

  function automatic void model_edge();
    bit can;
    int w;
    m_edge++;
    can   = !m_have || (m_edge - m_g >= int'(GAP) + 1);
    m_ack = 2'b00;
    if (rnd_in == 5'd0) m_err = 1;
    if (can && run && req != 2'b00 && rnd_in != 5'd0) begin
      if (req == 2'b01)      w = 0;
      else if (req == 2'b10) w = 1;
      else                   w = m_last ? 0 : 1;
      m_ack  = (w == 0) ? 2'b01 : 2'b10;
      m_rnd  = rnd_in;
      m_last = (w == 1);
      m_cnt  = m_cnt + 8'd1;
      m_have = 1;
      m_g    = m_edge;
    end
    m_busy = m_have && (m_edge - m_g < int'(GAP));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_pulse();
    rstn = 1'b0;
    model_reset();
    #2;
    rstn = 1'b1;
  endtask

  task automatic idle(input int n);
    run = 1'b0; req = 2'b00; rnd_in = 5'h3;
    for (int k = 0; k < n; k++) step();
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_ack", 32'(ack), 32'(m_ack));
    chk("model_rnd_out", 32'(rnd_out), 32'(m_rnd));
    chk("model_busy", 32'(busy), 32'(m_busy));
    chk("model_grant_cnt", 32'(grant_cnt), 32'(m_cnt));
    chk("model_lfsr_err", 32'(lfsr_err), 32'(m_err));
  endtask

  typedef struct {
    logic       run;
    logic [1:0] req;
    logic [4:0] rnd;
    logic [1:0] ack;
    logic       busy;
    logic [7:0] cnt;
    logic [4:0] rnd_o;
    logic       err;
  } vec_t;

  vec_t       tbl[13];
  logic [1:0] exp_q[$];
  logic [4:0] lfsr;
  logic [4:0] prev_rnd;
  int         last_c;
  int         n_ack;

  initial begin
    // inputs -> expected outputs after the edge
    tbl[0]  = '{1'b1, 2'b01, 5'h1f, 2'b01, 1'b1, 8'd1, 5'h1f, 1'b0};
    tbl[1]  = '{1'b1, 2'b11, 5'h03, 2'b00, 1'b1, 8'd1, 5'h1f, 1'b0};
    tbl[2]  = '{1'b1, 2'b11, 5'h04, 2'b00, 1'b1, 8'd1, 5'h1f, 1'b0};
    tbl[3]  = '{1'b1, 2'b11, 5'h05, 2'b00, 1'b1, 8'd1, 5'h1f, 1'b0};
    tbl[4]  = '{1'b1, 2'b11, 5'h06, 2'b00, 1'b0, 8'd1, 5'h1f, 1'b0};
    tbl[5]  = '{1'b1, 2'b11, 5'h07, 2'b10, 1'b1, 8'd2, 5'h07, 1'b0};
    tbl[6]  = '{1'b0, 2'b00, 5'h08, 2'b00, 1'b1, 8'd2, 5'h07, 1'b0};
    tbl[7]  = '{1'b0, 2'b00, 5'h09, 2'b00, 1'b1, 8'd2, 5'h07, 1'b0};
    tbl[8]  = '{1'b0, 2'b00, 5'h0a, 2'b00, 1'b1, 8'd2, 5'h07, 1'b0};
    tbl[9]  = '{1'b0, 2'b10, 5'h0b, 2'b00, 1'b0, 8'd2, 5'h07, 1'b0};
    tbl[10] = '{1'b0, 2'b10, 5'h0c, 2'b00, 1'b0, 8'd2, 5'h07, 1'b0};
    tbl[11] = '{1'b1, 2'b01, 5'h00, 2'b00, 1'b0, 8'd2, 5'h07, 1'b1};
    tbl[12] = '{1'b1, 2'b01, 5'h0d, 2'b01, 1'b1, 8'd3, 5'h0d, 1'b1};

    // reset
    rstn = 1'b0; run = 1'b0; req = 2'b00; rnd_in = 5'h1;
    repeat (2) @(posedge clk);
    #3;
    model_reset();
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_rnd_out", 32'(rnd_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant_cnt", 32'(grant_cnt), 32'h0);
    chk("rst_lfsr_err", 32'(lfsr_err), 32'h0);
    rstn = 1'b1;

    // vector table: first grant, gap, tie rotation, run gating, zero LFSR word
    for (int i = 0; i < 13; i++) begin
      run = tbl[i].run; req = tbl[i].req; rnd_in = tbl[i].rnd;
      step();
      chk($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_cnt", i), 32'(grant_cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_rnd_out", i), 32'(rnd_out), 32'(tbl[i].rnd_o));
      chk($sformatf("tbl%0d_err", i), 32'(lfsr_err), 32'(tbl[i].err));
    end

    // run=0 holds off a pending request; raising run grants on the next edge
    idle(6);
    run = 1'b0; req = 2'b10; rnd_in = 5'h09;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("run0_no_ack", 32'(ack), 32'h0);
    end
    run = 1'b1;
    step();
    chk("run1_ack", 32'(ack), 32'h2);

    // tie held continuously after reset: alternating acks, 5 cycles apart
    idle(1);
    reset_pulse();
    run = 1'b1; req = 2'b11; lfsr = 5'h01; rnd_in = lfsr;
    exp_q = {2'b01, 2'b10, 2'b01, 2'b10};
    n_ack = 0; last_c = 0;
    for (int c = 0; c < 40 && n_ack < 4; c++) begin
      step();
      lfsr = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
      rnd_in = lfsr;
      if (ack != 2'b00) begin
        chk("alt_ack", 32'(ack), 32'(exp_q.pop_front()));
        if (n_ack > 0) chk("alt_spacing", 32'(c - last_c), 32'd5);
        last_c = c;
        n_ack++;
      end
    end
    chk("alt_ack_count", 32'(n_ack), 32'd4);
    chk("alt_grant_cnt", 32'(grant_cnt), 32'd4);

    // reset in the middle of a gap after requester 0 won (pointer now favours 1)
    idle(6);
    run = 1'b1; req = 2'b01; rnd_in = 5'h15;
    step();
    chk("pre_rst_ack", 32'(ack), 32'h1);
    req = 2'b00;
    step();
    step();
    rstn = 1'b0;
    #1;
    chk("midgap_ack", 32'(ack), 32'h0);
    chk("midgap_rnd_out", 32'(rnd_out), 32'h0);
    chk("midgap_busy", 32'(busy), 32'h0);
    chk("midgap_grant_cnt", 32'(grant_cnt), 32'h0);
    chk("midgap_lfsr_err", 32'(lfsr_err), 32'h0);
    model_reset();
    #1;
    rstn = 1'b1;
    req = 2'b11; rnd_in = 5'h0e;
    step();
    chk("post_rst_tie_ack", 32'(ack), 32'h1);
    chk("post_rst_cnt", 32'(grant_cnt), 32'h1);

    // 256 grants from the free-running LFSR: counter wraps, rnd_out always fresh
    idle(1);
    reset_pulse();
    run = 1'b1; req = 2'b11; lfsr = 5'h13; rnd_in = lfsr;
    n_ack = 0; prev_rnd = 5'd0;
    for (int c = 0; c < 2000 && n_ack < 256; c++) begin
      step();
      lfsr = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
      rnd_in = lfsr;
      if (ack != 2'b00) begin
        chk("wrap_rnd_nonzero", 32'(rnd_out != 5'd0), 32'd1);
        if (n_ack > 0) chk("wrap_rnd_changes", 32'(rnd_out != prev_rnd), 32'd1);
        prev_rnd = rnd_out;
        n_ack++;
      end
    end
    chk("wrap_ack_count", 32'(n_ack), 32'd256);
    chk("wrap_grant_cnt", 32'(grant_cnt), 32'd0);
    chk("wrap_lfsr_err", 32'(lfsr_err), 32'd0);

    // randomized traffic against the reference model, with occasional resets
    for (int i = 0; i < 600; i++) begin
      run    = ($urandom_range(0, 7) != 0);
      req    = 2'($urandom_range(0, 3));
      rnd_in = 5'($urandom_range(0, 31));
      step();
      check_model();
      if ($urandom_range(0, 63) == 0) begin
        reset_pulse();
        check_model();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rand_arbiter.md
RAND_ARBITER -- requirements
Module: rand_arbiter

Interface
REQ-001 The block SHALL have parameter GAP, default 4, meaning the number of idle cycles enforced after each grant (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port rnd_in, input, 5 bits, the free-running pseudo-random word from the 5-bit LFSR.
REQ-005 The block SHALL have port run, input, 1 bit; when high, new grants are permitted.
REQ-006 The block SHALL have port req, input, 2 bits, level requests from requester 0 (left lane) and requester 1 (right lane).
REQ-007 The block SHALL have port ack, output, 2 bits, a one-cycle grant pulse per requester.
REQ-008 The block SHALL have port rnd_out, output, 5 bits, the random word delivered with ack.
REQ-009 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-010 The block SHALL have port grant_cnt, output, 8 bits, the total number of grants issued.
REQ-011 The block SHALL have port lfsr_err, output, 1 bit, a sticky flag indicating that the LFSR lock-up value was seen.

Function
REQ-012 The FSM SHALL have two states, IDLE and GAP, plus a 4-bit gap counter and a 1-bit round-robin pointer "last".
REQ-013 In IDLE the FSM SHALL grant when run=1, req!=0 and rnd_in!=0; otherwise it SHALL remain in IDLE with ack=0.
REQ-014 The winner SHALL be the sole requester when only one req bit is set, and SHALL be the requester not equal to last when both bits are set.
REQ-015 On the grant edge the block SHALL register ack[winner]=1 (other bit 0), rnd_out=rnd_in as sampled that cycle, last=winner, gap counter=GAP-1, grant_cnt=grant_cnt+1 (mod 256, wrapping 255 to 0), and state=GAP.
REQ-016 Latency SHALL be one cycle: a request seen in IDLE at edge t produces ack high during cycle t+1.
REQ-017 Ack SHALL be high for exactly one cycle; rnd_out SHALL hold its value until the next grant.
REQ-018 In GAP the FSM SHALL go to IDLE when the counter is 0, and SHALL otherwise decrement the counter; req and run SHALL be ignored in GAP.
REQ-019 Consecutive acks SHALL be separated by at least GAP+1 cycles (5 at default).
REQ-020 A requester SHALL deassert req in the cycle after it sees ack; a req still high on return to IDLE SHALL be treated as a new request.
REQ-021 When run=0 the block SHALL issue no new grant, and a GAP already in progress SHALL complete normally.
REQ-022 If rnd_in==0 is sampled in any state, lfsr_err SHALL set on the next edge and SHALL stay set until reset; no grant SHALL occur in a cycle where rnd_in==0.
REQ-023 busy SHALL be a registered indication equal to (state==GAP).

Reset
REQ-024 When rstn=0, asynchronously and regardless of state: state=IDLE, ack=0, rnd_out=0, busy=0, grant_cnt=0, lfsr_err=0, gap counter=0, last=1, so that requester 0 wins the first tie.
REQ-025 A reset asserted mid-GAP or during an ack cycle SHALL abort the operation; no ack SHALL appear on or after release until a fresh IDLE decision.
REQ-026 After rstn rises, the first grant SHALL be possible at the first rising edge at which the REQ-013 conditions hold.

Verification
REQ-027 Reset release with run=1, req=2'b01, rnd_in=5'h1f -> ack=2'b01 one cycle later, rnd_out=5'h1f, grant_cnt=1, busy=1 for 4 cycles.
REQ-028 req=2'b11 held continuously after reset -> acks alternate 01,10,01,10 with exactly 5 cycles between ack pulses, and grant_cnt=4 after the fourth ack.
REQ-029 run=0 with req=2'b10 for 20 cycles -> no ack; run raised -> ack=2'b10 on the next cycle.
REQ-030 rnd_in forced to 0 for one cycle with req=2'b01 in IDLE -> no ack that cycle, lfsr_err=1 permanently, grant on the next cycle once rnd_in is nonzero.
REQ-031 rstn pulsed low during GAP (cycle 2 after an ack) -> all outputs 0 immediately, last=1; with req=2'b11 after release -> ack=2'b01 first.
REQ-032 256 grants -> grant_cnt wraps to 0; every rnd_out is nonzero and differs from the preceding rnd_out when driven by the free-running LFSR.
